jump_ras_predict: RTL and testbench
===================================

JUMP_RAS_PREDICT -- requirements
Module: jump_ras_predict

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 8, meaning return-address-stack entries (power of 2, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of mispredict statistics counter.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallD  in  1  D stage held.
- flushD  in  1  D instruction killed.
- stallE  in  1  E stage held.
- flushE  in  1  E instruction killed.
- instrD  in  32  instruction in D.
- pcplus4D  in  32  PC+4 of D instruction.
- rd1D  in  32  rs read data in D.
- regwriteE, regwriteM  in  1 each  writeback enables.
- writeregE, writeregM  in  5 each  destination registers.
- rs_actualE  in  32  forwarded rs value of E instruction.
- jumpD  out  1  D holds j/jal/jr/jalr.
- jump_conflictD  out  1  stall request.
- pc_jumpD  out  32  D-stage jump target.
- ras_predD  out  1  pc_jumpD came from RAS.
- mispredictE  out  1  E-stage RAS prediction wrong.
- redirect_pcE  out  32  correct target on mispredict.
- ras_count  out  log2(RAS_DEPTH)+1  valid entries.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-004 SHALL decode j = opcode[31:27]==5'b00001; jr/jalr = opcode==0 and funct[5:1]==5'b00100; jumpD = j|jr.
REQ-005 SHALL form j target {pcplus4D[31:28], instrD[25:0], 2'b00}.
REQ-006 SHALL define hazard = jr & rs matches writeregE with regwriteE, or writeregM with regwriteM.
REQ-007 SHALL define pop = jr & rs==31 & ras_count!=0; ras_predD = pop & hazard.
REQ-008 SHALL drive pc_jumpD: j target if j; RAS top if ras_predD; else rd1D.
REQ-009 SHALL drive jump_conflictD = hazard & ~ras_predD.
REQ-010 SHALL define D advance = ~stallD & ~flushD & ~jump_conflictD; RAS changes only on advance or mispredict.
REQ-011 SHALL push pcplus4D+4 (delay-slot return) on jal (opcode 000011), and on jalr with rd==31.
REQ-012 SHALL pop on any jr/jalr meeting REQ-007, predicted or not.
REQ-013 SHALL, for push and pop in the same advance, replace the top entry; ras_count unchanged.
REQ-014 SHALL, on push when full, overwrite the oldest entry circularly; ras_count saturates at RAS_DEPTH.
REQ-015 SHALL, on pop when empty, do nothing; no prediction is made.
REQ-016 SHALL register ras_predD and predicted target into E when ~stallE; flushE (priority) clears the E copy; stallE holds it.
REQ-017 SHALL assert mispredictE combinationally when the E copy is valid and rs_actualE != predicted target; redirect_pcE = rs_actualE.
REQ-018 SHALL, on clock edge with mispredictE, clear ras_count to 0, discarding any same-cycle push/pop, and increment mispredict_cnt, saturating at all-ones.

Reset
REQ-019 SHALL, on rst, asynchronously clear ras_count, stack pointer, E-stage valid and mispredict_cnt to 0; RAS entry contents need not reset.
REQ-020 SHALL, with rst asserted, output mispredictE=0, ras_predD=0, ras_count=0, mispredict_cnt=0; jumpD, jump_conflictD and pc_jumpD remain combinational from inputs.
REQ-021 SHALL abandon any push/pop in flight when rst asserts mid-operation.

Configuration
REQ-022 SHALL gate the RAS with macro JUMP_RAS_PREDICT_EN: defined gives REQ-007..REQ-018 behaviour; undefined gives no RAS storage, ras_predD=0, jump_conflictD=hazard, pc_jumpD=j target or rd1D, mispredictE=0, redirect_pcE=0, ras_count=0, mispredict_cnt=0.

Verification
REQ-023 SHALL cover: jal at pcplus4D=0x00400008, advance, then jr $31 with regwriteE=1/writeregE=31 -> pc_jumpD=0x0040000C, ras_predD=1, jump_conflictD=0.
REQ-024 SHALL cover: predicted jr reaches E with rs_actualE=0x00400100 -> mispredictE=1, redirect_pcE=0x00400100, ras_count=0 next cycle, mispredict_cnt=1.
REQ-025 SHALL cover: 9 jal pushes with RAS_DEPTH=8 -> ras_count=8; 8 pops return the 8 newest addresses in LIFO order; 9th jr not predicted.
REQ-026 SHALL cover: jr $5 with regwriteM=1/writeregM=5 -> jump_conflictD=1, ras_predD=0, RAS unchanged while stalled.
REQ-027 SHALL cover: jal with stallD=1 for 3 cycles then advance -> exactly one push; rst mid-sequence -> ras_count=0 immediately.
REQ-028 SHALL cover: j 0x0100000 at pcplus4D=0x80000004 -> pc_jumpD=0x80400000; without JUMP_RAS_PREDICT_EN the REQ-023 stimulus gives jump_conflictD=1.

Source files
------------

// File: rtl/jump_ras_predict.sv
// jump_ras_predict
//   D-stage jump decode with a return-address stack (RAS) that predicts the
//   target of `jr $31` / `jalr $31` while the real $31 value is still in flight
//   in E or M. The prediction travels into E. There it is checked against the
//   forwarded rs value, and a wrong guess raises a redirect.
//
//   Optional feature macro: JUMP_RAS_PREDICT_EN
//     defined   -> RAS storage, prediction, E-stage check, mispredict counter
//     undefined -> plain decode; any jr hazard stalls; RAS outputs tied to 0
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   stallD/flushD          D-stage hold / kill
//   stallE/flushE          E-stage hold / kill
//   instrD, pcplus4D, rd1D D instruction, its PC+4, rs register read data
//   regwriteE/M, writeregE/M  in-flight writebacks, used for rs hazard detection
//   rs_actualE             forwarded rs of the E instruction
//   jumpD                  D holds j/jal/jr/jalr
//   jump_conflictD         stall request: jr source is not ready and no prediction
//   pc_jumpD               D-stage jump target
//   ras_predD              pc_jumpD came from the RAS
//   mispredictE            E-stage prediction was wrong
//   redirect_pcE           corrected target
//   ras_count              number of valid RAS entries
//   mispredict_cnt         saturating count of mispredictions
module jump_ras_predict #(
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stallD,
    input  logic                       flushD,
    input  logic                       stallE,
    input  logic                       flushE,
    input  logic [31:0]                instrD,
    input  logic [31:0]                pcplus4D,
    input  logic [31:0]                rd1D,
    input  logic                       regwriteE,
    input  logic                       regwriteM,
    input  logic [4:0]                 writeregE,
    input  logic [4:0]                 writeregM,
    input  logic [31:0]                rs_actualE,
    output logic                       jumpD,
    output logic                       jump_conflictD,
    output logic [31:0]                pc_jumpD,
    output logic                       ras_predD,
    output logic                       mispredictE,
    output logic [31:0]                redirect_pcE,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic [CNT_W-1:0]           mispredict_cnt
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic        is_j;
    logic        is_jr;
    logic        hazard;
    logic [31:0] j_tgt;

    assign opcode = instrD[31:26];
    assign funct  = instrD[5:0];
    assign rs     = instrD[25:21];
    // Covers both j (000010) and jal (000011).
    assign is_j   = (instrD[31:27] == 5'b00001);
    // Covers both jr (001000) and jalr (001001).
    assign is_jr  = (opcode == 6'd0) && (funct[5:1] == 5'b00100);
    assign jumpD  = is_j | is_jr;
    assign j_tgt  = {pcplus4D[31:28], instrD[25:0], 2'b00};
    assign hazard = is_jr && ((regwriteE && (writeregE == rs)) ||
                              (regwriteM && (writeregM == rs)));

`ifdef JUMP_RAS_PREDICT_EN
    logic [4:0]    rd;
    logic          is_jal;
    logic          is_jalr;
    logic          pop;
    logic          advance;
    logic          push_go;
    logic          pop_go;
    logic [PW-1:0] top_idx;
    logic [31:0]   top_val;

    logic [31:0]   ras_q [RAS_DEPTH];
    logic [CW-1:0] count_q, count_d;
    // sp_q is the next free slot. The oldest entry sits at sp_q - count_q,
    // so a push into a full stack lands on the oldest entry.
    logic [PW-1:0] sp_q, sp_d;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic          valE_q, valE_d;
    logic [31:0]   tgtE_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rd      = instrD[15:11];
    assign is_jal  = (opcode == 6'b000011);
    assign is_jalr = is_jr & funct[0];
    assign top_idx = sp_q - PW'(1);
    assign top_val = ras_q[top_idx];

    assign pop            = is_jr && (rs == 5'd31) && (count_q != '0);
    assign ras_predD      = pop & hazard;
    assign jump_conflictD = hazard & ~ras_predD;
    assign pc_jumpD       = is_j ? j_tgt : (ras_predD ? top_val : rd1D);

    assign advance = ~stallD & ~flushD & ~jump_conflictD;
    assign push_go = advance & (is_jal | (is_jalr & (rd == 5'd31)));
    assign pop_go  = advance & pop;

    assign mispredictE  = valE_q && (rs_actualE != tgtE_q);
    assign redirect_pcE = rs_actualE;
    assign ras_count      = count_q;
    assign mispredict_cnt = cnt_q;

    always_comb begin
        count_d = count_q;
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        cnt_d   = cnt_q;
        if (mispredictE) begin
            // A wrong guess means the stack no longer matches the call history.
            count_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (push_go && pop_go) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_go) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) count_d = count_q + CW'(1);
        end else if (pop_go) begin
            sp_d    = top_idx;
            count_d = count_q - CW'(1);
        end

        valE_d = valE_q;
        if (flushE)       valE_d = 1'b0;
        else if (!stallE) valE_d = ras_predD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sp_q    <= '0;
            valE_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            count_q <= count_d;
            sp_q    <= sp_d;
            valE_q  <= valE_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage and the E target copy carry data only; validity lives in the
    // reset-controlled registers above.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) ras_q[wr_idx] <= pcplus4D + 32'd4;
        if (!flushE && !stallE) tgtE_q <= top_val;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, stallD, flushD, stallE, flushE,
                         rs_actualE, pcplus4D[27:0]};

    assign ras_predD      = 1'b0;
    assign jump_conflictD = hazard;
    assign pc_jumpD       = is_j ? j_tgt : rd1D;
    assign mispredictE    = 1'b0;
    assign redirect_pcE   = '0;
    assign ras_count      = '0;
    assign mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_jump_ras_predict.sv
// Self-checking bench for jump_ras_predict. The reference stack is a bounded
// queue: the newest entry is at the back, and the oldest is dropped on overflow.
module tb_jump_ras_predict;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef JUMP_RAS_PREDICT_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stallD, flushD, stallE, flushE;
    logic [31:0] instrD, pcplus4D, rd1D, rs_actualE;
    logic        regwriteE, regwriteM;
    logic [4:0]  writeregE, writeregM;
    logic        jumpD, jump_conflictD, ras_predD, mispredictE;
    logic [31:0] pc_jumpD, redirect_pcE;
    logic [3:0]  ras_count;
    logic [CNT_W-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    jump_ras_predict #(.RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
        .stallE(stallE), .flushE(flushE), .instrD(instrD),
        .pcplus4D(pcplus4D), .rd1D(rd1D), .regwriteE(regwriteE),
        .regwriteM(regwriteM), .writeregE(writeregE), .writeregM(writeregM),
        .rs_actualE(rs_actualE), .jumpD(jumpD), .jump_conflictD(jump_conflictD),
        .pc_jumpD(pc_jumpD), .ras_predD(ras_predD), .mispredictE(mispredictE),
        .redirect_pcE(redirect_pcE), .ras_count(ras_count),
        .mispredict_cnt(mispredict_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [31:0] mq[$];
    bit          m_valE = 1'b0;
    logic [31:0] m_tgtE = 32'd0;
    int          mcnt = 0;

    localparam logic [31:0] JR31  = {6'd0, 5'd31, 15'd0, 6'b001000};
    localparam logic [31:0] NOP   = 32'd0;

    function automatic logic [31:0] mk_jal(input logic [25:0] t);
        return {6'b000011, t};
    endfunction

    task automatic eval(output bit jmp, output bit conf, output bit pred,
                        output bit push, output bit pop, output logic [31:0] pc);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rsf;
        logic [4:0] rdf;
        bit isj, isjr, haz;
        op  = instrD[31:26];
        fn  = instrD[5:0];
        rsf = instrD[25:21];
        rdf = instrD[15:11];
        isj  = (op == 6'd2) || (op == 6'd3);
        isjr = (op == 6'd0) && ((fn == 6'd8) || (fn == 6'd9));
        haz  = isjr && ((regwriteE && writeregE == rsf) || (regwriteM && writeregM == rsf));
        pop  = RAS_ON && isjr && (rsf == 5'd31) && (mq.size() != 0);
        pred = pop && haz;
        conf = haz && !pred;
        jmp  = isj || isjr;
        push = RAS_ON && ((op == 6'd3) || (op == 6'd0 && fn == 6'd9 && rdf == 5'd31));
        if (isj)       pc = {pcplus4D[31:28], instrD[25:0], 2'b00};
        else if (pred) pc = mq[mq.size()-1];
        else           pc = rd1D;
    endtask

    // Call at the negedge with inputs stable: compares, then advances the model.
    task automatic tick();
        bit jmp, conf, pred, push, pop, mis, adv;
        logic [31:0] pc;
        eval(jmp, conf, pred, push, pop, pc);
        mis = RAS_ON && m_valE && (rs_actualE != m_tgtE);
        check("jumpD", jumpD, jmp);
        check("jump_conflictD", jump_conflictD, conf);
        check("pc_jumpD", pc_jumpD, pc);
        check("ras_predD", ras_predD, pred);
        check("mispredictE", mispredictE, mis);
        check("redirect_pcE", redirect_pcE, RAS_ON ? rs_actualE : 32'd0);
        check("ras_count", ras_count, mq.size());
        check("mispredict_cnt", mispredict_cnt, mcnt);
        @(posedge clk);
        if (!rst) begin
            adv = !stallD && !flushD && !conf;
            if (mis) begin
                mq.delete();
                if (mcnt < (1 << CNT_W) - 1) mcnt++;
            end else if (adv) begin
                if (push && pop) mq[mq.size()-1] = pcplus4D + 32'd4;
                else if (push) begin
                    if (mq.size() == DEPTH) void'(mq.pop_front());
                    mq.push_back(pcplus4D + 32'd4);
                end else if (pop) void'(mq.pop_back());
            end
            if (flushE) m_valE = 1'b0;
            else if (!stallE) begin
                m_valE = pred;
                if (pred) m_tgtE = pc;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        stallD = 0; flushD = 0; stallE = 0; flushE = 0;
        instrD = NOP; pcplus4D = 32'h0040_0000; rd1D = 32'h0;
        regwriteE = 0; regwriteM = 0; writeregE = 0; writeregM = 0;
        rs_actualE = m_valE ? m_tgtE : 32'h0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_valE = 1'b0;
        mcnt = 0;
    endtask

    function automatic logic [31:0] rand_instr(input logic [4:0] rsr, input logic [4:0] rdr);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 8))
            0, 1:    return mk_jal(r[25:0]);
            2:       return {6'b000010, r[25:0]};
            3, 4:    return JR31;
            5:       return {6'd0, 5'd31, 5'd0, 5'd31, 5'd0, 6'b001001};
            6:       return {6'd0, rsr, 5'd0, 5'd0, 5'd0, 6'b001000};
            7:       return {6'd0, rsr, 5'd0, rdr, 5'd0, 6'b001001};
            default: return {6'b100011, r[25:0]};
        endcase
    endfunction

    initial begin
        logic [31:0] base;
        idle_inputs();
        rst = 1'b1;
        #2;
        // Outputs while reset is held
        check("rst ras_count", ras_count, 0);
        check("rst mispredict_cnt", mispredict_cnt, 0);
        check("rst mispredictE", mispredictE, 0);
        check("rst ras_predD", ras_predD, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // jal then predicted jr $31
        instrD = mk_jal(26'h123); pcplus4D = 32'h0040_0008;
        @(negedge clk); tick();
        instrD = JR31; regwriteE = 1; writeregE = 5'd31; rd1D = 32'hDEAD_BEEF;
        @(negedge clk);
        if (RAS_ON) begin
            check("d023 pc_jumpD", pc_jumpD, 32'h0040_000C);
            check("d023 ras_predD", ras_predD, 1);
            check("d023 conflict", jump_conflictD, 0);
        end else begin
            check("d028 conflict noras", jump_conflictD, 1);
        end
        tick();

        // Predicted jr in E resolves to a different address
        idle_inputs(); rs_actualE = 32'h0040_0100;
        @(negedge clk);
        if (RAS_ON) begin
            check("d024 mispredictE", mispredictE, 1);
            check("d024 redirect", redirect_pcE, 32'h0040_0100);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        check("d024 ras_count", ras_count, 0);
        check("d024 mispredict_cnt", mispredict_cnt, RAS_ON ? 1 : 0);
        tick();

        // Overflow then LIFO drain
        base = 32'h0010_0000;
        for (int i = 0; i < 9; i++) begin
            idle_inputs(); instrD = mk_jal(26'(i)); pcplus4D = base + 32'(i * 16);
            @(negedge clk); tick();
        end
        idle_inputs();
        @(negedge clk);
        check("d025 full count", ras_count, RAS_ON ? DEPTH : 0);
        tick();
        for (int i = 8; i >= 0; i--) begin
            idle_inputs(); instrD = JR31; regwriteE = 1; writeregE = 5'd31;
            @(negedge clk);
            if (RAS_ON && i > 0) check("d025 lifo pc", pc_jumpD, base + 32'(i * 16) + 32'd4);
            if (i == 0) check("d025 empty pred", ras_predD, 0);
            tick();
        end

        // Hazard stall on jr $5 leaves the stack alone
        idle_inputs(); instrD = mk_jal(26'h5); pcplus4D = 32'h0050_0000;
        @(negedge clk); tick();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); instrD = {6'd0, 5'd5, 15'd0, 6'b001000};
            regwriteM = 1; writeregM = 5'd5;
            @(negedge clk);
            check("d026 conflict", jump_conflictD, 1);
            tick();
        end

        // jal held in D for 3 cycles, then released, then async reset
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); instrD = mk_jal(26'h77); pcplus4D = 32'h0060_0000;
            stallD = (i < 3);
            @(negedge clk); tick();
        end
        idle_inputs();
        @(negedge clk);
        check("d027 one push", ras_count, RAS_ON ? 2 : 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("d027 rst count", ras_count, 0);
        @(negedge clk); tick();
        rst = 1'b0;

        // j with upper PC bits
        idle_inputs(); instrD = {6'b000010, 26'h0100000}; pcplus4D = 32'h8000_0004;
        @(negedge clk);
        check("d028 j target", pc_jumpD, 32'h8040_0000);
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] rsr, rdr;
            rsr = 5'($urandom_range(0, 31));
            rdr = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom);
            instrD    = rand_instr(rsr, rdr);
            pcplus4D  = $urandom & 32'hFFFF_FFFC;
            rd1D      = $urandom;
            regwriteE = $urandom_range(0, 1) == 1;
            regwriteM = $urandom_range(0, 1) == 1;
            writeregE = ($urandom_range(0, 1) == 1) ? instrD[25:21] : 5'($urandom);
            writeregM = ($urandom_range(0, 2) == 0) ? instrD[25:21] : 5'($urandom);
            stallD    = $urandom_range(0, 7) == 0;
            flushD    = $urandom_range(0, 9) == 0;
            stallE    = $urandom_range(0, 7) == 0;
            flushE    = $urandom_range(0, 9) == 0;
            rs_actualE = (m_valE && $urandom_range(0, 3) != 0) ? m_tgtE : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("rand rst count", ras_count, 0);
                @(negedge clk); tick();
                rst = 1'b0;
            end else begin
                @(negedge clk); tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
